// File: rtl/apb_bridge_arbiter.sv
// Round-robin arbiter sharing the AHB-side port of the AHB-to-APB bridge among NREQ requesters.
// A DATA-phase timeout keeps a hung APB slave from locking the bridge.
module apb_bridge_arbiter #(
    parameter int NREQ        = 2,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ-1:0]          req_write,
    input  logic [NREQ*ADDR_W-1:0]   req_addr,
    input  logic [NREQ*DATA_W-1:0]   req_wdata,
    output logic [NREQ-1:0]          req_grant,
    output logic [NREQ-1:0]          req_done,
    output logic                     req_err,
    output logic [DATA_W-1:0]        req_rdata,
    output logic                     valid,
    output logic                     Hwrite,
    output logic [ADDR_W-1:0]        Haddr,
    output logic [DATA_W-1:0]        Hwdata,
    input  logic                     Hreadyout,
    input  logic [DATA_W-1:0]        Hrdata
);

    localparam int IW = (NREQ > 2) ? 2 : 1;

    typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_t;

    state_t              state, state_nx;
    logic [IW-1:0]       last_grant, last_grant_nx;
    logic [7:0]          cnt, cnt_nx;

    logic                found;
    logic [IW-1:0]       winner;
    logic                sel_write;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_wdata;
    logic [NREQ-1:0]     sel_grant;

    logic                valid_nx;
    logic                hwrite_nx;
    logic [ADDR_W-1:0]   haddr_nx;
    logic [DATA_W-1:0]   hwdata_nx;
    logic [NREQ-1:0]     grant_nx;
    logic [NREQ-1:0]     done_nx;
    logic                err_nx;
    logic [DATA_W-1:0]   rdata_nx;

    // Round-robin pick: first requester above last_grant, otherwise wrap to the lowest one.
    always_comb begin
        found     = 1'b0;
        winner    = '0;
        sel_write = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        sel_grant = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!found && req_valid[i] && (IW'(i) > last_grant)) begin
                found  = 1'b1;
                winner = IW'(i);
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!found && req_valid[i]) begin
                found  = 1'b1;
                winner = IW'(i);
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (IW'(i) == winner) begin
                sel_write    = req_write[i];
                sel_addr     = req_addr[i*ADDR_W +: ADDR_W];
                sel_wdata    = req_wdata[i*DATA_W +: DATA_W];
                sel_grant[i] = 1'b1;
            end
        end
    end

    always_comb begin
        state_nx      = state;
        last_grant_nx = last_grant;
        cnt_nx        = cnt;
        valid_nx      = 1'b0;
        hwrite_nx     = Hwrite;
        haddr_nx      = Haddr;
        hwdata_nx     = Hwdata;
        grant_nx      = req_grant;
        done_nx       = '0;
        err_nx        = 1'b0;
        rdata_nx      = req_rdata;
        case (state)
            IDLE: begin
                if (found) begin
                    state_nx      = ADDR;
                    last_grant_nx = winner;
                    valid_nx      = 1'b1;
                    hwrite_nx     = sel_write;
                    haddr_nx      = sel_addr;
                    hwdata_nx     = sel_wdata;
                    grant_nx      = sel_grant;
                end
            end
            ADDR: state_nx = DATA;
            DATA: begin
                // A completion on the final allowed cycle still wins over the timeout.
                if (Hreadyout) begin
                    state_nx = DONE;
                    done_nx  = req_grant;
                    rdata_nx = Hrdata;
                end else if (cnt == 8'(TIMEOUT_CYC - 1)) begin
                    state_nx = DONE;
                    done_nx  = req_grant;
                    err_nx   = 1'b1;
                    rdata_nx = '0;
                end else begin
                    cnt_nx = cnt + 8'd1;
                end
            end
            DONE: begin
                state_nx = IDLE;
                grant_nx = '0;
                cnt_nx   = '0;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= IW'(NREQ - 1);
            cnt        <= '0;
            valid      <= 1'b0;
            Hwrite     <= 1'b0;
            Haddr      <= '0;
            Hwdata     <= '0;
            req_grant  <= '0;
            req_done   <= '0;
            req_err    <= 1'b0;
            req_rdata  <= '0;
        end else begin
            state      <= state_nx;
            last_grant <= last_grant_nx;
            cnt        <= cnt_nx;
            valid      <= valid_nx;
            Hwrite     <= hwrite_nx;
            Haddr      <= haddr_nx;
            Hwdata     <= hwdata_nx;
            req_grant  <= grant_nx;
            req_done   <= done_nx;
            req_err    <= err_nx;
            req_rdata  <= rdata_nx;
        end
    end

endmodule
